// File: rtl/fft_frame_buffer.sv
// Ping-pong frame assembler feeding the FFT core.
// Two sample banks are filled alternately and each full bank is streamed as an AXI-Stream burst.
module fft_frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 4096,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [DATA_WIDTH-1:0]  in_sample,
    input  logic                   in_valid,
    output logic [2*OUT_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [15:0]            dropped_frames
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam int AW = IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    typedef enum logic {
        W_FILL,
        W_DISCARD
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PREFETCH,
        R_STREAM
    } rd_state_e;

    logic [DATA_WIDTH-1:0] mem_q [2*FRAME_LEN];

    wr_state_e       wr_state_q, wr_state_d;
    logic            wr_bank_q, wr_bank_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [1:0]      full_q, full_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     dropped_q, dropped_d;

    rd_state_e       rd_state_q, rd_state_d;
    logic            rd_bank_q, rd_bank_d;
    logic            rd_next_q, rd_next_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic            wr_en;
    logic            rd_en;
    logic            last_xfer;
    logic [1:0]      busy;
    logic [1:0]      free;
    logic [1:0]      set_full;
    logic [1:0]      clr_full;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic signed [OUT_WIDTH-1:0] real_ext;

    assign wr_addr = {wr_bank_q, wr_idx_q};
    assign rd_addr = {rd_bank_q, rd_idx_q};

    // A bank whose tlast beat transfers this cycle already counts as free
    always_comb begin
        last_xfer = (rd_state_q == R_STREAM) && tvalid_q
                    && m_axis_tready && tlast_q;
        busy[0] = (rd_state_q != R_IDLE) && !rd_bank_q && !last_xfer;
        busy[1] = (rd_state_q != R_IDLE) && rd_bank_q && !last_xfer;
        free[0] = !full_q[0] && !busy[0];
        free[1] = !full_q[1] && !busy[1];
    end

    // Writer: fill the current bank, or count off a whole frame when no bank is free
    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        wr_idx_d   = wr_idx_q;
        overflow_d = overflow_q && !clear_overflow;
        dropped_d  = dropped_q;
        wr_en      = 1'b0;
        set_full   = 2'b00;
        unique case (wr_state_q)
            W_FILL: begin
                if (in_valid) begin
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        set_full = wr_bank_q ? 2'b10 : 2'b01;
                        wr_idx_d = '0;
                        if (free[!wr_bank_q]) begin
                            wr_bank_d = !wr_bank_q;
                        end else begin
                            wr_state_d = W_DISCARD;
                        end
                    end
                end
            end
            W_DISCARD: begin
                if (in_valid) begin
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d   = '0;
                        overflow_d = 1'b1;
                        if (dropped_q != 16'hFFFF) begin
                            dropped_d = dropped_q + 16'd1;
                        end
                        if (free[!wr_bank_q]) begin
                            wr_bank_d  = !wr_bank_q;
                            wr_state_d = W_FILL;
                        end else if (free[wr_bank_q]) begin
                            wr_state_d = W_FILL;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Reader: pick the oldest full bank, prefetch its first word, then stream
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_next_d  = rd_next_q;
        rd_idx_d   = rd_idx_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        rd_en      = 1'b0;
        clr_full   = 2'b00;
        unique case (rd_state_q)
            R_IDLE: begin
                if (full_q[rd_next_q]) begin
                    rd_bank_d  = rd_next_q;
                    rd_next_d  = !rd_next_q;
                    clr_full   = rd_next_q ? 2'b10 : 2'b01;
                    rd_idx_d   = '0;
                    rd_state_d = R_PREFETCH;
                end else if (full_q[!rd_next_q]) begin
                    rd_bank_d  = !rd_next_q;
                    rd_next_d  = rd_next_q;
                    clr_full   = rd_next_q ? 2'b01 : 2'b10;
                    rd_idx_d   = '0;
                    rd_state_d = R_PREFETCH;
                end
            end
            R_PREFETCH: begin
                rd_en      = 1'b1;
                rd_idx_d   = rd_idx_q + IW'(1);
                tvalid_d   = 1'b1;
                tlast_d    = (rd_idx_q == LAST_IDX);
                rd_state_d = R_STREAM;
            end
            R_STREAM: begin
                if (last_xfer) begin
                    tvalid_d   = 1'b0;
                    tlast_d    = 1'b0;
                    rd_state_d = R_IDLE;
                end else if ((!tvalid_q || m_axis_tready) && !tlast_q) begin
                    rd_en    = 1'b1;
                    rd_idx_d = rd_idx_q + IW'(1);
                    tvalid_d = 1'b1;
                    tlast_d  = (rd_idx_q == LAST_IDX);
                end
            end
            default: ;
        endcase
    end

    // Bank bookkeeping never sets and clears the same bank in one cycle
    always_comb begin
        full_d = (full_q | set_full) & ~clr_full;
    end

    // Control and handshake state
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_state_q <= W_FILL;
            wr_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
            dropped_q  <= 16'd0;
            rd_state_q <= R_IDLE;
            rd_bank_q  <= 1'b0;
            rd_next_q  <= 1'b0;
            rd_idx_q   <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_bank_q  <= wr_bank_d;
            wr_idx_q   <= wr_idx_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_next_q  <= rd_next_d;
            rd_idx_q   <= rd_idx_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    // Sample RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in_sample;
        end
    end

    // Registered read port doubles as the output hold register during stalls
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[rd_addr];
        end
    end

    assign real_ext       = OUT_WIDTH'($signed(rdata_q));
    assign m_axis_tdata   = {{OUT_WIDTH{1'b0}}, real_ext};
    assign m_axis_tvalid  = tvalid_q;
    assign m_axis_tlast   = tlast_q;
    assign overflow       = overflow_q;
    assign dropped_frames = dropped_q;

endmodule
